// File: rtl/channel_packer.sv
// Serial-to-parallel packer feeding the six-input channel adder. It collects
// six channel words, issues them as one group, and tags the adder result.
module channel_packer #(
  parameter int DW           = 23,
  parameter int NCH          = 6,
  parameter int ADD_LAT      = 3,
  parameter int FRAME_GROUPS = 100
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          hold,
  input  logic          clr,
  output logic [DW-1:0] d1,
  output logic [DW-1:0] d2,
  output logic [DW-1:0] d3,
  output logic [DW-1:0] d4,
  output logic [DW-1:0] d5,
  output logic [DW-1:0] d6,
  output logic          out_valid,
  output logic          res_valid,
  output logic          res_last
);

  localparam int              GW       = (FRAME_GROUPS > 1) ? $clog2(FRAME_GROUPS) : 1;
  localparam logic [GW-1:0]   GRP_LAST = GW'(FRAME_GROUPS - 1);
  localparam logic [2:0]      CH_LAST  = 3'(NCH - 1);

  logic [2:0]         ch;
  logic [GW-1:0]      grp;
  logic [DW-1:0]      col [0:NCH-2];
  logic               last_q;
  logic [ADD_LAT-1:0] dl_v;
  logic [ADD_LAT-1:0] dl_l;
  logic               accept;
  logic               issue;

  assign in_ready = ~hold;
  assign accept   = in_valid & in_ready & ~clr;
  assign issue    = accept & (ch == CH_LAST);

  // clr takes priority over any accept, including a sixth word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch  <= '0;
      grp <= '0;
    end else if (clr) begin
      ch  <= '0;
      grp <= '0;
    end else if (accept) begin
      if (issue) begin
        ch  <= '0;
        grp <= (grp == GRP_LAST) ? '0 : grp + GW'(1);
      end else begin
        ch <= ch + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH - 1; i++) col[i] <= '0;
    end else begin
      for (int i = 0; i < NCH - 1; i++) begin
        if (accept && (ch == 3'(i))) col[i] <= in_data;
      end
    end
  end

  // The sixth word bypasses the collect bank so groups can stream back to back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
      d4 <= '0;
      d5 <= '0;
      d6 <= '0;
    end else if (issue) begin
      d1 <= col[0];
      d2 <= col[1];
      d3 <= col[2];
      d4 <= col[3];
      d5 <= col[4];
      d6 <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      out_valid <= issue;
      last_q    <= issue & (grp == GRP_LAST);
    end
  end

  // Stage 0 loads as the adder samples d1..d6, so the tail matches its result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_v <= '0;
      dl_l <= '0;
    end else begin
      dl_v[0] <= out_valid;
      dl_l[0] <= last_q;
      for (int i = 1; i < ADD_LAT; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_l[i] <= dl_l[i-1];
      end
    end
  end

  assign res_valid = dl_v[ADD_LAT-1];
  assign res_last  = dl_l[ADD_LAT-1] & dl_v[ADD_LAT-1];

endmodule

// File: tb/tb_channel_packer.sv
// Bench for channel_packer: a behavioural model predicts each issued group,
// its issue cycle, result cycle and frame-last tag; a monitor checks them.
module tb_channel_packer;

  localparam int DW      = 23;
  localparam int ADD_LAT = 3;
  localparam int FG      = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          hold;
  logic          clr;
  logic [DW-1:0] d1, d2, d3, d4, d5, d6;
  logic          out_valid;
  logic          res_valid;
  logic          res_last;

  channel_packer #(.DW(DW), .NCH(6), .ADD_LAT(ADD_LAT), .FRAME_GROUPS(FG)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .hold(hold), .clr(clr),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6),
    .out_valid(out_valid), .res_valid(res_valid), .res_last(res_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0][DW-1:0] d;
    logic               last;
    int                 out_cyc;
    int                 res_cyc;
  } grp_t;

  typedef struct {
    logic          v;
    logic          h;
    logic          c;
    logic [DW-1:0] w;
    logic          exp_rdy;
    logic          exp_iss;
  } row_t;

  grp_t gq[$];
  grp_t rq[$];
  row_t tbl[$];

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int n_ov = 0, n_rv = 0, n_rl = 0;
  int mch = 0, mgrp = 0;
  logic [DW-1:0] mcol [5];
  logic last_rdy;
  logic [DW-1:0] dout [6];

  assign dout[0] = d1;
  assign dout[1] = d2;
  assign dout[2] = d3;
  assign dout[3] = d4;
  assign dout[4] = d5;
  assign dout[5] = d6;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    nchk++;
    nerr++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Drive one cycle of inputs and advance the model; returns after the edge
  task automatic drive(input logic v, input logic [DW-1:0] w, input logic h, input logic c);
    grp_t g;
    in_valid = v;
    in_data  = w;
    hold     = h;
    clr      = c;
    if (c) begin
      mch  = 0;
      mgrp = 0;
    end else if (v && !h && rst_n) begin
      if (mch < 5) begin
        mcol[mch] = w;
        mch++;
      end else begin
        for (int k = 0; k < 5; k++) g.d[k] = mcol[k];
        g.d[5]    = w;
        g.last    = (mgrp == FG - 1);
        g.out_cyc = cyc + 1;
        g.res_cyc = cyc + 1 + ADD_LAT;
        gq.push_back(g);
        mch  = 0;
        mgrp = (mgrp + 1) % FG;
      end
    end
    #1 last_rdy = in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic add_row(input logic v, input logic h, input logic c, input int w, input logic iss);
    row_t r;
    r.v = v; r.h = h; r.c = c; r.w = DW'(w); r.exp_rdy = ~h; r.exp_iss = iss;
    tbl.push_back(r);
  endtask

  always @(negedge clk) begin
    grp_t g;
    if (!rst_n) begin
      chk("out_valid_in_reset", out_valid, 1'b0);
      chk("res_valid_in_reset", res_valid, 1'b0);
    end else begin
      if (gq.size() > 0 && gq[0].out_cyc < cyc) begin
        fail_now("missing out_valid");
        void'(gq.pop_front());
      end
      if (rq.size() > 0 && rq[0].res_cyc < cyc) begin
        fail_now("missing res_valid");
        void'(rq.pop_front());
      end
      if (out_valid) begin
        n_ov++;
        if (gq.size() == 0) fail_now("unexpected out_valid");
        else begin
          g = gq.pop_front();
          chk("out_cycle", 64'(cyc), 64'(g.out_cyc));
          for (int k = 0; k < 6; k++) chk($sformatf("d%0d", k + 1), 64'(dout[k]), 64'(g.d[k]));
          rq.push_back(g);
        end
      end
      if (res_valid) begin
        n_rv++;
        if (res_last) n_rl++;
        if (rq.size() == 0) fail_now("unexpected res_valid");
        else begin
          g = rq.pop_front();
          chk("res_cycle", 64'(cyc), 64'(g.res_cyc));
          chk("res_last", res_last, g.last);
        end
      end
      if (res_last && !res_valid) fail_now("res_last without res_valid");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int ov0, rv0, rl0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; hold = 1'b0; clr = 1'b0;

    // hold/clear table
    for (int i = 1; i <= 6; i++) add_row(1, 0, 0, i, i == 6);
    for (int i = 1; i <= 3; i++) add_row(1, 0, 0, i, 0);
    for (int i = 0; i < 5; i++)  add_row(1, 1, 0, 'h7ff, 0);
    for (int i = 4; i <= 6; i++) add_row(1, 0, 0, i, i == 6);
    for (int i = 1; i <= 4; i++) add_row(1, 0, 0, i, 0);
    add_row(1, 0, 1, 5, 0);
    for (int i = 7; i <= 12; i++) add_row(1, 0, 0, i, i == 12);
    for (int i = 21; i <= 25; i++) add_row(1, 0, 0, i, 0);
    add_row(1, 0, 1, 26, 0);
    add_row(0, 0, 0, 0, 0);

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_last", res_last, 1'b0);
    chk("rst_d1", d1, '0);
    chk("rst_d6", d6, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    hold = 1'b1; #1;
    chk("rst_in_ready_hold", in_ready, 1'b0);
    hold = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // single group
    ov0 = n_ov; rv0 = n_rv;
    for (int i = 1; i <= 6; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
    idle(6);
    chk("single_ov_count", 64'(n_ov - ov0), 64'd1);
    chk("single_rv_count", 64'(n_rv - rv0), 64'd1);

    // streaming with negative and max-width words
    ov0 = n_ov; rv0 = n_rv;
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, (i % 5 == 0) ? DW'(-(i + 1)) : DW'($urandom), 1'b0, 1'b0);
      chk("stream_in_ready", last_rdy, 1'b1);
    end
    idle(6);
    chk("stream_ov_count", 64'(n_ov - ov0), 64'd4);
    chk("stream_rv_count", 64'(n_rv - rv0), 64'd4);

    // hold and clear vectors
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].w, tbl[i].h, tbl[i].c);
      chk($sformatf("tbl%0d_in_ready", i), last_rdy, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_issue", i), out_valid, tbl[i].exp_iss);
    end
    idle(6);

    // frame wrap: five groups after a clear, only the fourth is tagged last
    drive(1'b0, '0, 1'b0, 1'b1);
    rl0 = n_rl; rv0 = n_rv;
    for (int i = 0; i < 30; i++) drive(1'b1, DW'(1000 + i), 1'b0, 1'b0);
    idle(6);
    chk("wrap_rv_count", 64'(n_rv - rv0), 64'd5);
    chk("wrap_last_count", 64'(n_rl - rl0), 64'd1);

    // reset one cycle after an issue
    rv0 = n_rv;
    for (int i = 1; i <= 6; i++) drive(1'b1, DW'(50 + i), 1'b0, 1'b0);
    idle(1);
    rst_n = 1'b0;
    mch = 0; mgrp = 0;
    gq.delete(); rq.delete();
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_res_valid", res_valid, 1'b0);
    chk("midrst_d1", d1, '0);
    chk("midrst_d6", d6, '0);
    drive(1'b1, DW'('h55), 1'b0, 1'b0);
    drive(1'b1, DW'('h56), 1'b0, 1'b0);
    rst_n = 1'b1;
    idle(4);
    chk("midrst_no_res", 64'(n_rv - rv0), 64'd0);
    for (int i = 31; i <= 36; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
    idle(8);
    chk("midrst_fresh_res", 64'(n_rv - rv0), 64'd1);

    chk("groups_drained", 64'(gq.size()), 64'd0);
    chk("results_drained", 64'(rq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
